// File: rtl/ll_pkg.sv
// Shared types and default widths for the linked-list engine read front end.
package ll_pkg;

   localparam int PTR_WD     = 4;
   localparam int WR_DATA_WD = 8;

   typedef struct packed {
      logic              pop;
      logic [PTR_WD-1:0] pos;
   } t_ll_rd_req;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } t_rd_intf_st;

endpackage

// File: rtl/ll_sync_fifo.sv
// Small synchronous FIFO with a combinational head output (no read latency).
// Pointers carry one extra wrap bit so full and empty fall out of pointer compares.
module ll_sync_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_push_en;
   logic             w_pop_en;

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign dout  = r_mem[r_rd_ptr[AW-1:0]];

   // A simultaneous pop frees the slot being written, so push is legal even when full.
   assign w_push_en = push && (!full || pop);
   assign w_pop_en  = pop && !empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_en)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_en) r_mem[r_wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/ll_req_resp_intf.sv
// Host read/pop request front end: buffers requests, issues one at a time to the
// read controller and returns responses. Bounds check enabled by LL_RD_BOUNDS_CHK_EN.
module ll_req_resp_intf #(
   parameter int PTR_WD         = ll_pkg::PTR_WD,
   parameter int WR_DATA_WD     = ll_pkg::WR_DATA_WD,
   parameter int REQ_FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  host_rd_req_vld,
   input  logic                  host_rd_req_pop,
   input  logic [PTR_WD-1:0]     host_rd_pos,
   output logic                  host_rd_req_rdy,
   output logic                  host_rd_resp_vld,
   output logic [WR_DATA_WD-1:0] host_rd_resp_data,
   output logic                  host_rd_resp_err,
   input  logic                  host_rd_resp_rdy,
   input  logic [PTR_WD:0]       ll_node_cnt,
   output logic                  rd_req_vld,
   output logic                  rd_req_pop,
   output logic [PTR_WD-1:0]     rd_node_at_pos,
   input  logic                  rd_ctrl_ready,
   input  logic                  rd_data_out_vld,
   input  logic [WR_DATA_WD-1:0] rd_data_out
);

   import ll_pkg::*;

   localparam int ENTRY_WD = PTR_WD + 1;

   t_rd_intf_st           r_state;
   t_rd_intf_st           w_state_next;
   logic                  w_fifo_push;
   logic                  w_fifo_pop;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic [ENTRY_WD-1:0]   w_fifo_din;
   logic [ENTRY_WD-1:0]   w_fifo_dout;
   logic                  w_head_pop;
   logic [PTR_WD-1:0]     w_head_pos;
   logic                  w_reject;
   logic                  r_req_pop;
   logic [PTR_WD-1:0]     r_req_pos;
   logic [WR_DATA_WD-1:0] r_resp_data;
   logic                  r_resp_err;

   assign w_fifo_din      = {host_rd_req_pop, host_rd_pos};
   assign w_fifo_push     = host_rd_req_vld && !w_fifo_full;
   assign host_rd_req_rdy = !w_fifo_full;
   assign {w_head_pop, w_head_pos} = w_fifo_dout;

   ll_sync_fifo #(
      .WIDTH (ENTRY_WD),
      .DEPTH (REQ_FIFO_DEPTH)
   ) u_req_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (w_fifo_push),
      .din     (w_fifo_din),
      .pop     (w_fifo_pop),
      .full    (w_fifo_full),
      .empty   (w_fifo_empty),
      .dout    (w_fifo_dout)
   );

`ifdef LL_RD_BOUNDS_CHK_EN
   assign w_reject = w_head_pop ? (ll_node_cnt == '0)
                                : ({1'b0, w_head_pos} >= ll_node_cnt);
`else
   logic w_unused_node_cnt;
   assign w_unused_node_cnt = ^ll_node_cnt;
   assign w_reject          = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_fifo_pop   = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_fifo_empty && rd_ctrl_ready) begin
               w_fifo_pop   = 1'b1;
               w_state_next = w_reject ? RESP : ISSUE;
            end
         end
         ISSUE:   if (rd_data_out_vld)  w_state_next = RESP;
         RESP:    if (host_rd_resp_rdy) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_req_pop   <= 1'b0;
         r_req_pos   <= '0;
         r_resp_data <= '0;
         r_resp_err  <= 1'b0;
      end else if (w_fifo_pop) begin
         r_req_pop   <= w_head_pop;
         r_req_pos   <= w_head_pos;
         r_resp_data <= '0;
         r_resp_err  <= w_reject;
      end else if (r_state == ISSUE && rd_data_out_vld) begin
         r_resp_data <= rd_data_out;
         r_resp_err  <= 1'b0;
      end
   end

   // The controller samples rd_req_vld in its data-valid cycle; masking stops a duplicate start.
   assign rd_req_vld        = (r_state == ISSUE) && !rd_data_out_vld;
   assign rd_req_pop        = r_req_pop;
   assign rd_node_at_pos    = r_req_pos;
   assign host_rd_resp_vld  = (r_state == RESP);
   assign host_rd_resp_data = r_resp_data;
   assign host_rd_resp_err  = r_resp_err;

endmodule

// File: tb/tb_ll_req_resp_intf.sv
// Directed + randomized bench for ll_req_resp_intf with a behavioural read-controller
// and a list-level reference model; honours LL_RD_BOUNDS_CHK_EN when defined.
module tb_ll_req_resp_intf;
   import ll_pkg::*;

   localparam int PW = 4;
   localparam int DW = 8;

   typedef struct {
      logic          err;
      logic [DW-1:0] data;
   } t_exp;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          host_rd_req_vld = 1'b0;
   logic          host_rd_req_pop = 1'b0;
   logic [PW-1:0] host_rd_pos = '0;
   logic          host_rd_req_rdy;
   logic          host_rd_resp_vld;
   logic [DW-1:0] host_rd_resp_data;
   logic          host_rd_resp_err;
   logic          host_rd_resp_rdy = 1'b0;
   logic [PW:0]   ll_node_cnt;
   logic          rd_req_vld;
   logic          rd_req_pop;
   logic [PW-1:0] rd_node_at_pos;
   logic          rd_ctrl_ready;
   logic          rd_data_out_vld = 1'b0;
   logic [DW-1:0] rd_data_out = '0;

   always #5 clk = ~clk;

   ll_req_resp_intf #(.PTR_WD(PW), .WR_DATA_WD(DW), .REQ_FIFO_DEPTH(4)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .host_rd_req_vld   (host_rd_req_vld),
      .host_rd_req_pop   (host_rd_req_pop),
      .host_rd_pos       (host_rd_pos),
      .host_rd_req_rdy   (host_rd_req_rdy),
      .host_rd_resp_vld  (host_rd_resp_vld),
      .host_rd_resp_data (host_rd_resp_data),
      .host_rd_resp_err  (host_rd_resp_err),
      .host_rd_resp_rdy  (host_rd_resp_rdy),
      .ll_node_cnt       (ll_node_cnt),
      .rd_req_vld        (rd_req_vld),
      .rd_req_pop        (rd_req_pop),
      .rd_node_at_pos    (rd_node_at_pos),
      .rd_ctrl_ready     (rd_ctrl_ready),
      .rd_data_out_vld   (rd_data_out_vld),
      .rd_data_out       (rd_data_out)
   );

   // Environment: the linked list as seen by the read controller.
   logic [DW-1:0] env_list [16];
   int            env_cnt = 0;
   assign ll_node_cnt = env_cnt[PW:0];

   // Reference model: the same list advanced at request-accept time.
   logic [DW-1:0] mdl_list [16];
   int            mdl_cnt = 0;
   t_exp          exp_q [$];

   int n_pass = 0, n_total = 0, n_acc = 0, n_resp = 0;
   logic ctrl_en = 1'b1;
   int   rc_lat = 4;

   // Behavioural read controller, active on the falling edge.
   logic          rc_busy = 1'b0;
   int            rc_cnt = 0;
   logic          rc_pop = 1'b0;
   logic [PW-1:0] rc_pos = '0;
   logic          prev_vld = 1'b0;
   int            win_cnt = 0, pop_win_cnt = 0, overlap_cnt = 0, unstable_cnt = 0;

   assign rd_ctrl_ready = ctrl_en && !rc_busy && !rd_data_out_vld;

   always @(negedge clk) begin
      if (!reset_n) begin
         rc_busy = 1'b0;
         rd_data_out_vld = 1'b0;
         prev_vld = 1'b0;
      end else begin
         if (rd_req_vld && rd_data_out_vld) overlap_cnt++;
         if (rd_req_vld && !prev_vld) begin
            win_cnt++;
            if (rd_req_pop) pop_win_cnt++;
         end
         if (rc_busy && rd_req_vld && (rd_req_pop !== rc_pop || rd_node_at_pos !== rc_pos))
            unstable_cnt++;
         prev_vld = rd_req_vld;
         if (rd_data_out_vld) begin
            rd_data_out_vld = 1'b0;
            rc_busy = 1'b0;
         end else if (rc_busy) begin
            rc_cnt--;
            if (rc_cnt == 0) begin
               rd_data_out_vld = 1'b1;
               if (rc_pop) begin
                  rd_data_out = env_list[0];
                  for (int i = 0; i < 15; i++) env_list[i] = env_list[i+1];
                  env_cnt--;
               end else begin
                  rd_data_out = env_list[rc_pos];
               end
            end
         end else if (rd_req_vld) begin
            rc_busy = 1'b1;
            rc_pop  = rd_req_pop;
            rc_pos  = rd_node_at_pos;
            rc_cnt  = (rc_lat > 0) ? rc_lat : int'($urandom_range(1, 5));
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_list(input int n);
      for (int i = 0; i < 16; i++) begin
         env_list[i] = 8'($urandom);
         mdl_list[i] = env_list[i];
      end
      env_cnt = n;
      mdl_cnt = n;
   endtask

   task automatic put(input int i, input logic [DW-1:0] v);
      env_list[i] = v;
      mdl_list[i] = v;
   endtask

   // Drive one cycle's inputs; record accepted requests and check completed responses.
   task automatic drive(input logic v, input logic p, input logic [PW-1:0] pos, input logic rr);
      t_ll_rd_req req;
      t_exp       e;
      t_exp       got;
      host_rd_req_vld  = v;
      host_rd_req_pop  = p;
      host_rd_pos      = pos;
      host_rd_resp_rdy = rr;
      if (v && host_rd_req_rdy) begin
         req.pop = p;
         req.pos = pos;
`ifdef LL_RD_BOUNDS_CHK_EN
         e.err = req.pop ? (mdl_cnt == 0) : (int'(req.pos) >= mdl_cnt);
`else
         e.err = 1'b0;
`endif
         if (e.err) e.data = '0;
         else if (req.pop) begin
            e.data = mdl_list[0];
            for (int i = 0; i < 15; i++) mdl_list[i] = mdl_list[i+1];
            mdl_cnt--;
         end else e.data = mdl_list[req.pos];
         exp_q.push_back(e);
         n_acc++;
      end
      if (host_rd_resp_vld && rr) begin
         n_resp++;
         if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
         else begin
            got = exp_q.pop_front();
            check("resp_data", host_rd_resp_data, got.data);
            check("resp_err", host_rd_resp_err, got.err);
         end
      end
   endtask

   task automatic drain(input int budget);
      int b = 0;
      while (exp_q.size() > 0 && b < budget) begin
         tick();
         drive(1'b0, 1'b0, '0, 1'b1);
         b++;
      end
      check("drain_timeout", exp_q.size(), 0);
      tick();
      drive(1'b0, 1'b0, '0, 1'b1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, p0, u0, r0, b, seen;
      logic v, p, rr;
      logic [PW-1:0] pos;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_rdy", host_rd_req_rdy, 1);
      check("rst_resp_vld", host_rd_resp_vld, 0);
      check("rst_resp_data", host_rd_resp_data, 0);
      check("rst_resp_err", host_rd_resp_err, 0);
      check("rst_rd_req_vld", rd_req_vld, 0);
      check("rst_rd_req_pop", rd_req_pop, 0);
      check("rst_rd_pos", rd_node_at_pos, 0);
      reset_n = 1'b1;

      // Peek pos=2 of {0x11,0x22,0x33}, read latency 4
      set_list(3);
      put(0, 8'h11); put(1, 8'h22); put(2, 8'h33);
      rc_lat = 4;
      w0 = win_cnt;
      tick(); drive(1'b1, 1'b0, 4'd2, 1'b1);
      tick(); drive(1'b0, 1'b0, '0, 1'b1);
      check("t1_vld_after_accept", rd_req_vld, 0);
      tick(); drive(1'b0, 1'b0, '0, 1'b1);
      check("t1_vld_after_load", rd_req_vld, 1);
      drain(40);
      check("t1_windows", win_cnt - w0, 1);
      check("t1_overlap", overlap_cnt, 0);

      // Pop of head 0xA5 with three nodes
      set_list(3);
      put(0, 8'hA5);
      p0 = pop_win_cnt; u0 = unstable_cnt; w0 = win_cnt;
      tick(); drive(1'b1, 1'b1, 4'($urandom), 1'b1);
      drain(40);
      check("t2_pop_windows", pop_win_cnt - p0, 1);
      check("t2_windows", win_cnt - w0, 1);
      check("t2_req_stable", unstable_cnt - u0, 0);

      // Five back-to-back requests with the host stalled
      set_list(8);
      rc_lat = 0;
      r0 = n_acc;
      b = 0;
      while (n_acc - r0 < 5 && b < 40) begin
         tick();
         p = (mdl_cnt > 1) && ($urandom_range(0, 2) == 0);
         drive(1'b1, p, 4'($urandom_range(0, 7)), 1'b0);
         b++;
      end
      check("t3_accepts", n_acc - r0, 5);
      tick(); drive(1'b1, 1'b0, 4'd1, 1'b0);
      check("t3_rdy_low_when_full", host_rd_req_rdy, 0);
      seen = 0;
      b = 0;
      while (!host_rd_resp_vld && b < 30) begin
         tick(); drive(1'b1, 1'b0, 4'd1, 1'b0);
         if (host_rd_req_rdy) seen++;
         b++;
      end
      check("t3_resp_seen", host_rd_resp_vld, 1);
      repeat (5) begin
         tick(); drive(1'b1, 1'b0, 4'd1, 1'b0);
         if (host_rd_req_rdy) seen++;
      end
      check("t3_rdy_stays_low", seen, 0);
      check("t3_resp_held", host_rd_resp_vld, 1);
      check("t3_hold_data", host_rd_resp_data, exp_q[0].data);
      check("t3_queued", n_acc - r0, 5);
      r0 = n_resp;
      drain(200);
      check("t3_drained", n_resp - r0, 5);

      // Bounds handling at pos == ll_node_cnt
      set_list(5);
      rc_lat = 2;
      w0 = win_cnt;
`ifdef LL_RD_BOUNDS_CHK_EN
      tick(); drive(1'b1, 1'b0, 4'd5, 1'b1);
      tick(); drive(1'b0, 1'b0, '0, 1'b1);
      check("t4_no_resp_yet", host_rd_resp_vld, 0);
      tick();
      check("t4_rej_vld", host_rd_resp_vld, 1);
      check("t4_rej_err", host_rd_resp_err, 1);
      check("t4_rej_data", host_rd_resp_data, 0);
      drive(1'b0, 1'b0, '0, 1'b1);
      tick(); drive(1'b1, 1'b0, 4'd4, 1'b1);
      drain(40);
      check("t4_windows", win_cnt - w0, 1);
      set_list(0);
      w0 = win_cnt;
      tick(); drive(1'b1, 1'b1, '0, 1'b1);
      drain(40);
      check("t4_pop_empty_windows", win_cnt - w0, 0);
`else
      tick(); drive(1'b1, 1'b0, 4'd5, 1'b1);
      drain(40);
      check("t4_issued_unchecked", win_cnt - w0, 1);
`endif

      // Controller busy for 10 cycles with a request queued
      set_list(6);
      ctrl_en = 1'b0;
      tick(); drive(1'b1, 1'b0, 4'd1, 1'b1);
      seen = 0;
      repeat (10) begin
         tick(); drive(1'b0, 1'b0, '0, 1'b1);
         if (rd_req_vld) seen++;
      end
      check("t5_no_issue", seen, 0);
      ctrl_en = 1'b1;
      tick();
      check("t5_issue_next", rd_req_vld, 1);
      drive(1'b0, 1'b0, '0, 1'b1);
      drain(40);

      // Asynchronous reset during ISSUE with two requests queued
      set_list(8);
      rc_lat = 8;
      tick(); drive(1'b1, 1'b0, 4'd1, 1'b1);
      tick(); drive(1'b1, 1'b0, 4'd2, 1'b1);
      tick(); drive(1'b1, 1'b0, 4'd3, 1'b1);
      tick(); drive(1'b0, 1'b0, '0, 1'b1);
      check("t6_in_issue", rd_req_vld, 1);
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_rd_req_vld", rd_req_vld, 0);
      check("t6_rst_req_rdy", host_rd_req_rdy, 1);
      check("t6_rst_resp_vld", host_rd_resp_vld, 0);
      check("t6_rst_rd_pos", rd_node_at_pos, 0);
      check("t6_rst_rd_pop", rd_req_pop, 0);
      exp_q.delete();
      set_list(8);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      w0 = win_cnt;
      seen = 0;
      repeat (15) begin
         tick(); drive(1'b0, 1'b0, '0, 1'b1);
         if (host_rd_resp_vld) seen++;
      end
      check("t6_no_resp", seen, 0);
      check("t6_no_issue", win_cnt - w0, 0);

      // Randomized traffic with random host and controller stalls
      set_list(12);
      rc_lat = 0;
      r0 = n_resp;
      w0 = n_acc;
      repeat (300) begin
         tick();
         ctrl_en = ($urandom_range(0, 7) != 0);
         v   = $urandom_range(0, 1);
         p   = (mdl_cnt > 1) && ($urandom_range(0, 3) == 0);
         pos = 4'($urandom_range(0, 15));
         rr  = ($urandom_range(0, 3) != 0);
         drive(v, p, pos, rr);
      end
      ctrl_en = 1'b1;
      drain(400);
      check("rand_resp_count", n_resp - r0, n_acc - w0);
      check("rand_overlap", overlap_cnt, 0);
      check("rand_req_stable", unstable_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
